alarm_sequencer: RTL and testbench

- Sits directly downstream of the alarm clock's `Buzz` output and replaces its raw level as the signal that drives the sounder.
- Detects the start of an alarm and sounds a beep cadence.
- Handles snooze, with a limited number of snoozes, plus dismiss and an automatic shut-off timeout.
- Runs on the same `Pulse` tick as the clock, one pulse per second.

---
 rtl/alarm_seq_pkg.sv | 28 ++
 rtl/rise_det.sv | 37 +++
 rtl/alarm_sequencer.sv | 174 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_seq_pkg.sv
// alarm_seq_pkg
// Shared definitions for the alarm sequencer: the FSM state type, default
// timing parameters and small constant helpers used to size counters.
package alarm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } aseq_state_t;

    localparam int NS_DEFAULT           = 60;
    localparam int SNOOZE_MIN_DEFAULT   = 9;
    localparam int RING_TIMEOUT_DEFAULT = 120;
    localparam int BEEP_ON_DEFAULT      = 1;
    localparam int BEEP_OFF_DEFAULT     = 1;
    localparam int MAX_SNOOZE_DEFAULT   = 2;

    // Bits needed to count 0..v-1, never less than one bit.
    function automatic int bits_for(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_det.sv
// rise_det
// One-bit registered rising-edge detector. The history flop resets to
// RST_VAL; resetting it high means a level that is already high when reset
// releases is not reported as an edge.
//   clk_sys : clock
//   rst_b   : asynchronous active-low reset
//   d_in    : level to watch (synchronous to clk_sys)
//   rise    : combinational, high in the cycle d_in is high and was low
module rise_det
    import alarm_seq_pkg::*;
#(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_sys,
    input  logic rst_b,
    input  logic d_in,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d_in;
    end

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d_in & ~prev_q;

endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer
// Turns the clock's raw alarm-match level into a beeping sounder drive with
// snooze (limited count), dismiss and an automatic ring timeout. Runs on the
// one-per-second Pulse tick.
//   Pulse      : clock, rising edge
//   Reset      : asynchronous active-low reset
//   Buzz       : raw alarm-match level from the clock
//   Alarmon    : alarm enable, low forces silence
//   Snooze     : snooze button level, rising edge acts
//   Dismiss    : dismiss level
//   Buzz_out   : sounder drive (registered)
//   Ringing    : high while in RING (registered)
//   Snoozing   : high while in SNOOZE (registered)
//   Snooze_cnt : snoozes used in the current alarm event (registered)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | silent, waiting for a Buzz rising edge with Alarmon high
// RING   | sounding the beep cadence, ring timer running
// SNOOZE | silent, snooze timer running, returns to RING on expiry
module alarm_sequencer
    import alarm_seq_pkg::*;
#(
    parameter int NS           = NS_DEFAULT,
    parameter int SNOOZE_MIN   = SNOOZE_MIN_DEFAULT,
    parameter int RING_TIMEOUT = RING_TIMEOUT_DEFAULT,
    parameter int BEEP_ON      = BEEP_ON_DEFAULT,
    parameter int BEEP_OFF     = BEEP_OFF_DEFAULT,
    parameter int MAX_SNOOZE   = MAX_SNOOZE_DEFAULT
) (
    input  logic                            Pulse,
    input  logic                            Reset,
    input  logic                            Buzz,
    input  logic                            Alarmon,
    input  logic                            Snooze,
    input  logic                            Dismiss,
    output logic                            Buzz_out,
    output logic                            Ringing,
    output logic                            Snoozing,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] Snooze_cnt
);

    localparam int SNZ_CYC = SNOOZE_MIN * NS;
    localparam int TW      = bits_for(max_int(RING_TIMEOUT, SNZ_CYC));
    localparam int PER     = BEEP_ON + BEEP_OFF;
    localparam int PW      = bits_for(PER);
    localparam int CW      = $clog2(MAX_SNOOZE + 1);

    localparam logic [TW-1:0] RING_LAST  = TW'(RING_TIMEOUT - 1);
    localparam logic [TW-1:0] SNZ_LAST   = TW'(SNZ_CYC - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(PER - 1);

    aseq_state_t   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] snz_cnt_q, snz_cnt_d;
    logic          buzz_out_q, buzz_out_d;
    logic          ringing_q, ringing_d;
    logic          snoozing_q, snoozing_d;

    logic buzz_rise;
    logic snz_rise;
    logic snz_take;
    logic state_entry;

    // Both history flops reset high so levels already asserted at reset
    // release do not count as fresh edges.
    rise_det #(.RST_VAL(1'b1)) u_buzz_rise (
        .clk_sys (Pulse),
        .rst_b   (Reset),
        .d_in    (Buzz),
        .rise    (buzz_rise)
    );

    rise_det #(.RST_VAL(1'b1)) u_snz_rise (
        .clk_sys (Pulse),
        .rst_b   (Reset),
        .d_in    (Snooze),
        .rise    (snz_rise)
    );

    always_comb begin
        state_d  = state_q;
        snz_take = 1'b0;

        if (!Alarmon) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (buzz_rise) begin
                        state_d = RING;
                    end
                end
                RING: begin
                    // Snooze outranks timeout; a press at the snooze limit
                    // falls through so the ring carries on.
                    if (Dismiss) begin
                        state_d = IDLE;
                    end else if (snz_rise && (int'(snz_cnt_q) < MAX_SNOOZE)) begin
                        state_d  = SNOOZE;
                        snz_take = 1'b1;
                    end else if (timer_q == RING_LAST) begin
                        state_d = IDLE;
                    end
                end
                SNOOZE: begin
                    if (Dismiss) begin
                        state_d = IDLE;
                    end else if (timer_q == SNZ_LAST) begin
                        state_d = RING;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        state_entry = (state_d != state_q);

        if ((state_d == IDLE) || state_entry) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        if ((state_d != RING) || state_entry || (phase_q == PHASE_LAST)) begin
            phase_d = '0;
        end else begin
            phase_d = phase_q + PW'(1);
        end

        if (state_d == IDLE) begin
            snz_cnt_d = '0;
        end else if (snz_take) begin
            snz_cnt_d = snz_cnt_q + CW'(1);
        end else begin
            snz_cnt_d = snz_cnt_q;
        end

        // Outputs are decoded from the next-state values so the registered
        // copies line up with the state they describe.
        buzz_out_d = (state_d == RING) && (int'(phase_d) < BEEP_ON);
        ringing_d  = (state_d == RING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge Pulse or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            phase_q    <= '0;
            snz_cnt_q  <= '0;
            buzz_out_q <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            phase_q    <= phase_d;
            snz_cnt_q  <= snz_cnt_d;
            buzz_out_q <= buzz_out_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
        end
    end

    assign Buzz_out   = buzz_out_q;
    assign Ringing    = ringing_q;
    assign Snoozing   = snoozing_q;
    assign Snooze_cnt = snz_cnt_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// tb_alarm_sequencer
// Self-checking bench for alarm_sequencer with default parameters: a vector
// table, hand-written multi-cycle scenarios and a randomized run, all also
// compared every cycle against a behavioural model of the alarm rules.
module tb_alarm_sequencer;

    localparam int RT   = 120;
    localparam int SL   = 9 * 60;
    localparam int BON  = 1;
    localparam int BOFF = 1;
    localparam int PER  = BON + BOFF;
    localparam int MAXS = 2;

    logic       Pulse = 1'b0;
    logic       Reset;
    logic       Buzz;
    logic       Alarmon;
    logic       Snooze;
    logic       Dismiss;
    logic       Buzz_out;
    logic       Ringing;
    logic       Snoozing;
    logic [1:0] Snooze_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    alarm_sequencer dut (
        .Pulse      (Pulse),
        .Reset      (Reset),
        .Buzz       (Buzz),
        .Alarmon    (Alarmon),
        .Snooze     (Snooze),
        .Dismiss    (Dismiss),
        .Buzz_out   (Buzz_out),
        .Ringing    (Ringing),
        .Snoozing   (Snoozing),
        .Snooze_cnt (Snooze_cnt)
    );

    always #5 Pulse = ~Pulse;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 silent, 1 ringing, 2 snoozing; m_age counts
    // whole seconds spent in the current ring or snooze.
    int m_mode;
    int m_age;
    int m_used;
    bit m_pb;
    bit m_ps;

    task automatic model_reset();
        m_mode = 0;
        m_age  = 0;
        m_used = 0;
        m_pb   = 1'b1;
        m_ps   = 1'b1;
    endtask

    task automatic go_mode(input int m);
        m_mode = m;
        m_age  = 0;
        if (m == 0) m_used = 0;
    endtask

    task automatic model_step();
        bit br, sr;
        br   = Buzz && !m_pb;
        sr   = Snooze && !m_ps;
        m_pb = Buzz;
        m_ps = Snooze;
        if (!Alarmon)                                    go_mode(0);
        else if (m_mode != 0 && Dismiss)                 go_mode(0);
        else if (m_mode == 1 && sr && m_used < MAXS) begin
            m_used++;
            go_mode(2);
        end
        else if (m_mode == 1 && m_age == RT - 1)         go_mode(0);
        else if (m_mode == 2 && m_age == SL - 1)         go_mode(1);
        else if (m_mode == 0 && br)                      go_mode(1);
        else if (m_mode != 0)                            m_age++;
    endtask

    task automatic check_model();
        chk("model_ringing",  Ringing,    (m_mode == 1));
        chk("model_snoozing", Snoozing,   (m_mode == 2));
        chk("model_cnt",      Snooze_cnt, m_used);
        chk("model_buzz_out", Buzz_out,   (m_mode == 1) && ((m_age % PER) < BON));
    endtask

    task automatic tick();
        @(posedge Pulse);
        if (Reset) model_step();
        else       model_reset();
        #1;
        check_model();
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_ring();
        Buzz = 1'b0;
        tick();
        Buzz = 1'b1;
        tick();
        chk("ring_entry_ringing",  Ringing,  1);
        chk("ring_entry_buzz_out", Buzz_out, 1);
    endtask

    // Waits out a snooze; returns number of ticks until Snoozing dropped.
    task automatic wait_snooze(output int n);
        n = 0;
        while (Snoozing && n < 700) begin
            tick();
            n++;
        end
    endtask

    typedef struct {
        logic buzz;
        logic alarmon;
        logic snooze;
        logic dismiss;
        logic ring;
        logic snz;
        logic bo;
        int   cnt;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int n;
        int rc;

        //            buzz  aon   snz   dis   ring  snz   bo    cnt
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        Reset   = 1'b0;
        Buzz    = 1'b0;
        Alarmon = 1'b1;
        Snooze  = 1'b0;
        Dismiss = 1'b0;
        model_reset();
        #2;
        chk("reset_buzz_out", Buzz_out,   0);
        chk("reset_ringing",  Ringing,    0);
        chk("reset_snoozing", Snoozing,   0);
        chk("reset_cnt",      Snooze_cnt, 0);
        @(posedge Pulse);
        #1 Reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            Buzz    = vecs[i].buzz;
            Alarmon = vecs[i].alarmon;
            Snooze  = vecs[i].snooze;
            Dismiss = vecs[i].dismiss;
            tick();
            chk($sformatf("vec%0d_ringing", i),  Ringing,    vecs[i].ring);
            chk($sformatf("vec%0d_snoozing", i), Snoozing,   vecs[i].snz);
            chk($sformatf("vec%0d_buzz_out", i), Buzz_out,   vecs[i].bo);
            chk($sformatf("vec%0d_cnt", i),      Snooze_cnt, vecs[i].cnt);
        end

        // Basic ring: Buzz rises at cycle 10 and is held throughout.
        Buzz = 1'b0;
        tick_n(10);
        Buzz = 1'b1;
        tick();
        chk("basic_ringing",  Ringing,  1);
        chk("basic_buzz_out", Buzz_out, 1);
        n = 0;
        while (Ringing && n < 200) begin
            tick();
            n++;
            if (Ringing) chk("basic_cadence", Buzz_out, (n % 2 == 0));
        end
        chk("basic_ring_len", n, RT);
        rc = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (Ringing) rc++;
        end
        chk("basic_no_retrigger", rc, 0);

        // Snooze at ring cycle 5, two full snoozes, then the limit.
        start_ring();
        tick_n(4);
        Snooze = 1'b1;
        tick();
        chk("snz1_snoozing", Snoozing,   1);
        chk("snz1_cnt",      Snooze_cnt, 1);
        chk("snz1_buzz_out", Buzz_out,   0);
        Snooze = 1'b0;
        wait_snooze(n);
        chk("snz1_len",          n,        SL);
        chk("snz1_back_ringing", Ringing,  1);
        chk("snz1_back_buzz",    Buzz_out, 1);
        Snooze = 1'b1;
        tick();
        chk("snz2_cnt", Snooze_cnt, 2);
        Snooze = 1'b0;
        wait_snooze(n);
        chk("snz2_len", n, SL);
        Snooze = 1'b1;
        tick();
        chk("snz_limit_ringing",  Ringing,    1);
        chk("snz_limit_snoozing", Snoozing,   0);
        chk("snz_limit_cnt",      Snooze_cnt, 2);
        Snooze = 1'b0;
        tick();
        Dismiss = 1'b1;
        tick();
        chk("dismiss_ringing", Ringing,    0);
        chk("dismiss_cnt",     Snooze_cnt, 0);
        Dismiss = 1'b0;

        // Alarmon dropped mid-snooze; the old expiry must not ring.
        start_ring();
        Snooze = 1'b1;
        tick();
        Snooze = 1'b0;
        tick_n(10);
        Alarmon = 1'b0;
        tick();
        chk("aoff_snoozing", Snoozing, 0);
        chk("aoff_ringing",  Ringing,  0);
        Alarmon = 1'b1;
        rc = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (Ringing) rc++;
        end
        chk("aoff_no_ring", rc, 0);

        // Snooze in the timeout cycle, then Dismiss in the expiry cycle.
        start_ring();
        tick_n(RT - 1);
        Snooze = 1'b1;
        tick();
        chk("timeout_snz_snoozing", Snoozing, 1);
        chk("timeout_snz_ringing",  Ringing,  0);
        Snooze = 1'b0;
        tick_n(SL - 1);
        Dismiss = 1'b1;
        tick();
        chk("expiry_dismiss_ringing",  Ringing,  0);
        chk("expiry_dismiss_snoozing", Snoozing, 0);
        Dismiss = 1'b0;

        // Buzz already high across reset release: no ring.
        Reset = 1'b0;
        model_reset();
        Buzz = 1'b1;
        tick_n(3);
        Reset = 1'b1;
        rc = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Ringing) rc++;
        end
        chk("reset_release_no_ring", rc, 0);

        // Reset mid-snooze drops snooze credit immediately.
        start_ring();
        Snooze = 1'b1;
        tick();
        chk("pre_reset_cnt", Snooze_cnt, 1);
        #3 Reset = 1'b0;
        #1;
        chk("rst_snz_snoozing", Snoozing,   0);
        chk("rst_snz_cnt",      Snooze_cnt, 0);
        model_reset();
        Snooze = 1'b0;
        @(posedge Pulse);
        #1 Reset = 1'b1;

        // Reset mid-ring silences without waiting for a clock edge.
        start_ring();
        tick_n(2);
        chk("pre_reset_buzz", Buzz_out, 1);
        #3 Reset = 1'b0;
        #1;
        chk("rst_ring_ringing",  Ringing,  0);
        chk("rst_ring_buzz_out", Buzz_out, 0);
        model_reset();
        @(posedge Pulse);
        #1 Reset = 1'b1;

        // Randomized traffic against the model.
        for (int i = 0; i < 25000; i++) begin
            if ($urandom_range(0, 39) == 0) Buzz = ~Buzz;
            if (Alarmon) begin
                if ($urandom_range(0, 599) == 0) Alarmon = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                Alarmon = 1'b1;
            end
            if ($urandom_range(0, 11) == 0) Snooze = ~Snooze;
            Dismiss = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
